// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - payload/config request bundle between FIFO read side and the UART transmitter
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      par_en;
    logic                      par_typ;
    logic                      stop2;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      busy;

    modport master (
        output p_data, data_valid, par_en, par_typ, stop2, prescale,
        input  busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, stop2, prescale,
        output busy
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter with prescaler, parity, 1/2 stop bits
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter bit MSB_FIRST      = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_cfg_if.slave tx_if,
    output logic         tx_out,
    output logic         frame_done
);
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [BCW-1:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      par_bit_q, par_bit_d;
    logic                      par_en_q, par_en_d;
    logic                      stop2_q, stop2_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bit_end;
    logic                      shift_out;

    assign bit_end = (cnt_q == presc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (tx_if.data_valid) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_d     = '0;
                    presc_d   = tx_if.prescale;
                    shift_d   = tx_if.p_data;
                    par_bit_d = (^tx_if.p_data) ^ tx_if.par_typ;
                    par_en_d  = tx_if.par_en;
                    stop2_d   = tx_if.stop2;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // bit_q counts stop bits: the frame ends after stop bit index stop2_q
                if (bit_end) begin
                    if (bit_q == BCW'(stop2_q)) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next-state values
    always_comb begin
        shift_out = MSB_FIRST ? shift_d[DATA_WIDTH-1] : shift_d[0];
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_out;
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == presc_d) && (bit_d == BCW'(stop2_d));
    end

    assign tx_out     = tx_q;
    assign frame_done = done_q;
    assign tx_if.busy = busy_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - table-driven and directed checks of uart_tx_cfg frames, gaps and aborts
module tb_uart_tx_cfg;
    logic clk = 1'b0;
    logic rst;
    logic tx0, fd0, tx1, fd1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) if0 ();
    uart_tx_cfg_if #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) if1 ();

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .MSB_FIRST(1'b0)) u0 (
        .clk        (clk),
        .rst        (rst),
        .tx_if      (if0),
        .tx_out     (tx0),
        .frame_done (fd0)
    );

    uart_tx_cfg #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6), .MSB_FIRST(1'b1)) u1 (
        .clk        (clk),
        .rst        (rst),
        .tx_if      (if1),
        .tx_out     (tx1),
        .frame_done (fd1)
    );

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic        stop2;
        logic [5:0]  prescale;
        logic [15:0] bits;
        int          nbits;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_idle(input bit sel, input string tag);
        chk({tag, " busy"},       32'(sel ? if1.busy : if0.busy), 32'd0);
        chk({tag, " tx"},         32'(sel ? tx1 : tx0),           32'd1);
        chk({tag, " frame_done"}, 32'(sel ? fd1 : fd0),           32'd0);
    endtask

    // Called at the sample point of the first frame cycle; returns at the last one
    task automatic expect_frame(input bit sel, input string tag, input logic [15:0] bits,
                                input int nbits, input int p, input bit pulse_dv);
        int len;
        int idx;
        len = nbits * (p + 1);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (pulse_dv && i == 1) if0.data_valid = 1'b1;
            if (pulse_dv && i == 2) if0.data_valid = 1'b0;
            idx = i / (p + 1);
            chk($sformatf("%s tx c%0d", tag, i + 1),   32'(sel ? tx1 : tx0),           32'(bits[nbits-1-idx]));
            chk($sformatf("%s busy c%0d", tag, i + 1), 32'(sel ? if1.busy : if0.busy), 32'd1);
            chk($sformatf("%s done c%0d", tag, i + 1), 32'(sel ? fd1 : fd0),           32'(i == len - 1));
        end
    endtask

    task automatic send_vec(input vec_t v, input string tag);
        @(negedge clk);
        if0.p_data     = v.data;
        if0.par_en     = v.par_en;
        if0.par_typ    = v.par_typ;
        if0.stop2      = v.stop2;
        if0.prescale   = v.prescale;
        if0.data_valid = 1'b1;
        @(negedge clk);
        if0.data_valid = 1'b0;
        if0.p_data     = ~v.data;
        if0.par_en     = ~v.par_en;
        if0.par_typ    = ~v.par_typ;
        if0.stop2      = ~v.stop2;
        if0.prescale   = 6'd7;
        expect_frame(1'b0, tag, v.bits, v.nbits, int'(v.prescale), 1'b1);
        @(negedge clk);
        check_idle(1'b0, {tag, " gap"});
    endtask

    initial begin
        rst            = 1'b1;
        if0.p_data     = '0;
        if0.data_valid = 1'b0;
        if0.par_en     = 1'b0;
        if0.par_typ    = 1'b0;
        if0.stop2      = 1'b0;
        if0.prescale   = '0;
        if1.p_data     = '0;
        if1.data_valid = 1'b0;
        if1.par_en     = 1'b0;
        if1.par_typ    = 1'b0;
        if1.stop2      = 1'b0;
        if1.prescale   = '0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 6'd0, 16'(11'b01010010101),  11};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 6'd0, 16'(11'b01010010111),  11};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 6'd0, 16'(10'b0101001011),   10};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 6'd3, 16'(11'b00011110011),  11};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 6'd1, 16'(12'b000000000111), 12};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 6'd2, 16'(11'b01111111101),  11};

        repeat (3) @(negedge clk);
        check_idle(1'b0, "reset u0");
        check_idle(1'b1, "reset u1");
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            send_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // data_valid held high: back-to-back frames with exactly one idle clock between
        @(negedge clk);
        if0.p_data     = 8'h01;
        if0.par_en     = 1'b0;
        if0.par_typ    = 1'b0;
        if0.stop2      = 1'b0;
        if0.prescale   = 6'd0;
        if0.data_valid = 1'b1;
        @(negedge clk);
        if0.p_data = 8'h02;
        expect_frame(1'b0, "b2b f1", 16'(10'b0100000001), 10, 0, 1'b0);
        @(negedge clk);
        check_idle(1'b0, "b2b gap");
        @(negedge clk);
        expect_frame(1'b0, "b2b f2", 16'(10'b0010000001), 10, 0, 1'b0);
        if0.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle(1'b0, $sformatf("b2b tail%0d", i));
        end

        // Reset during clock 5 of a frame aborts it without frame_done
        @(negedge clk);
        if0.p_data     = 8'hFF;
        if0.par_en     = 1'b0;
        if0.stop2      = 1'b0;
        if0.prescale   = 6'd2;
        if0.data_valid = 1'b1;
        @(negedge clk);
        if0.data_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            chk($sformatf("abort tx c%0d", i),   32'(tx0),      32'(i > 3));
            chk($sformatf("abort busy c%0d", i), 32'(if0.busy), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle(1'b0, "abort reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle(1'b0, $sformatf("abort after%0d", i));
        end
        send_vec(vecs[5], "post abort");

        // 5-bit MSB-first instance
        @(negedge clk);
        if1.p_data     = 5'b10011;
        if1.par_en     = 1'b1;
        if1.par_typ    = 1'b0;
        if1.stop2      = 1'b0;
        if1.prescale   = 6'd0;
        if1.data_valid = 1'b1;
        @(negedge clk);
        if1.data_valid = 1'b0;
        expect_frame(1'b1, "w5msb", 16'(8'b01001111), 8, 0, 1'b0);
        @(negedge clk);
        check_idle(1'b1, "w5msb gap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. It supersedes the fixed 8-bit, one-clock-per-bit transmitter.
- Adds generic data width, selectable bit order, 1/2 stop bits and an integer clocks-per-bit prescaler.
- Adds a frame-complete strobe.
- Sits between the system-control/FIFO read side and the serial TX pin, in the TX clock domain.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..16.
PRESCALE_WIDTH, 6, width of the prescale input; max bit period is 2^PRESCALE_WIDTH clocks.
MSB_FIRST, 0, 0 = LSB transmitted first (standard UART), 1 = MSB first.

Ports:
clk  input  1  TX clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
p_data  input  DATA_WIDTH  parallel payload.
data_valid  input  1  payload request; accepted only when busy=0.
par_en  input  1  1 = append parity bit.
par_typ  input  1  0 = even parity, 1 = odd parity.
stop2  input  1  0 = one stop bit, 1 = two stop bits.
prescale  input  PRESCALE_WIDTH  each bit lasts prescale+1 clocks.
tx_out  output  1  serial line, registered, idle high.
busy  output  1  registered; high while a frame is in progress.
frame_done  output  1  registered one-clock pulse at frame end.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: tx_out=1, busy=0, frame_done=0, state=IDLE, bit counter=0, prescale counter=0, shift register=0.
- Reset mid-frame: the frame is aborted. The next edge yields the reset values, and no frame_done is produced.
- Accept:
  - Condition: data_valid=1 and busy=0 at a clock edge.
  - Captured on that edge: p_data, par_en, par_typ, stop2, prescale.
  - The parity bit is computed from the captured data at the same edge.
  - Input changes after accept have no effect on the current frame.
- data_valid while busy=1 is ignored and dropped; there is no queueing.
- Latency: tx_out and busy reflect the start bit starting on the edge after the accept edge, i.e. the first cycle after accept shows tx_out=0, busy=1.
- States:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA repeats DATA_WIDTH bits, then goes to PARITY if par_en, else STOP.
  - PARITY -> STOP.
  - STOP runs 1 or 2 bits, then -> IDLE.
  - Each state/bit is held for prescale+1 clocks by a down/up prescale counter. Transitions occur only when the counter reaches the captured prescale value.
- Bit values:
  - start = 0.
  - data bits are taken from the captured word per MSB_FIRST.
  - parity = XOR(data) XOR par_typ.
  - stop = 1.
- Frame length in clocks: (1 + DATA_WIDTH + par_en + 1 + stop2) * (prescale+1).
- busy is high for exactly that many clocks.
- frame_done is 1 during the last clock of the final stop bit (concurrent with busy=1). It is 0 otherwise.
- The cycle after frame_done: busy=0, tx_out=1. A new accept is possible on that edge, so the minimum inter-frame gap is exactly one idle clock at tx_out=1.
- prescale=0 gives one clock per bit, matching the legacy transmitter's timing plus the one-clock gap.
- Counters never wrap inside a bit. The bit counter width is ceil(log2(DATA_WIDTH+1)).

Test Plan:
1. Default params, prescale=0, par_en=1, par_typ=0, stop2=0, p_data=8'hA5, single-cycle data_valid -> tx_out sequence from cycle+1: 0,1,0,1,0,0,1,0,1,0,1; busy high 11 clocks; frame_done on clock 11.
2. Same with par_typ=1 -> parity bit 1. With par_en=0 -> 10-bit frame, busy 10 clocks.
3. prescale=3, par_en=0, stop2=1, p_data=8'h3C -> each bit 4 clocks wide; busy 44 clocks; tx_out high for final 8 clocks of frame; prescale changed to 7 mid-frame has no effect.
4. data_valid held high continuously with p_data 8'h01 then 8'h02 -> two frames; exactly one idle-high clock with busy=0 between them; data_valid pulses during busy produce no extra frame.
5. rst asserted at clock 5 of frame (p_data=8'hFF, prescale=2) -> next edge tx_out=1, busy=0, no frame_done; a following accept produces a clean full frame.
6. DATA_WIDTH=5, MSB_FIRST=1, prescale=0, par_en=1, par_typ=0, p_data=5'b10011 -> tx_out 0,1,0,0,1,1,1,1; busy 8 clocks.
